// File: rtl/csr_trap_sequencer.sv
// CSR port arbiter and trap/mret sequencer for the MEM stage.
// Build option: TRAP_VECTORED_EN enables mtvec vectored mode for interrupts.
module csr_trap_sequencer #(
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_epc,
  input  logic        mret_req,
  input  logic        csr_req,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_src,
  input  logic [1:0]  csr_mode,
  output logic        csr_gnt,
  output logic [31:0] csr_rdata_out,
  output logic        cf_w,
  output logic [11:0] cf_raddr,
  output logic [11:0] cf_waddr,
  output logic [31:0] cf_wdata,
  output logic [1:0]  cf_wsc,
  input  logic [31:0] cf_rdata,
  input  logic [31:0] cf_mstatus,
  output logic        busy,
  output logic        flush_all,
  output logic        regwrite_cancel,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE, T_MSTATUS, T_MEPC, T_MCAUSE,
    T_REDIR, R_MSTATUS, R_REDIR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic [31:0] r_target;
  logic [31:0] w_tvec_base;
  logic [31:0] w_trap_tgt;
  logic        w_acc_trap;

  assign w_acc_trap  = (r_state == IDLE) && trap_req;
  assign w_tvec_base = {cf_rdata[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign w_trap_tgt = (cf_rdata[1:0] == 2'b01 && r_cause[31])
                    ? w_tvec_base + {r_cause[29:0], 2'b00}
                    : w_tvec_base;
`else
  assign w_trap_tgt = w_tvec_base;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_epc    <= '0;
      r_cause  <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc_trap) begin
        r_epc   <= trap_epc;
        r_cause <= trap_cause;
      end
      if (r_state == T_MCAUSE) r_target <= w_trap_tgt;
      if (r_state == R_MSTATUS) r_target <= cf_rdata;
    end
  end

  always_comb begin
    w_next          = r_state;
    csr_gnt         = 1'b0;
    csr_rdata_out   = '0;
    cf_w            = 1'b0;
    cf_raddr        = '0;
    cf_waddr        = '0;
    cf_wdata        = '0;
    cf_wsc          = 2'b00;
    busy            = 1'b0;
    flush_all       = 1'b0;
    regwrite_cancel = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    if (rst) begin
      busy = (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (trap_req) begin
            flush_all       = 1'b1;
            regwrite_cancel = 1'b1;
            w_next          = T_MSTATUS;
          end else if (mret_req) begin
            flush_all = 1'b1;
            w_next    = R_MSTATUS;
          end else if (csr_req) begin
            csr_gnt       = 1'b1;
            cf_raddr      = csr_addr;
            csr_rdata_out = cf_rdata;
            cf_waddr      = csr_addr;
            cf_wdata      = csr_src;
            cf_wsc        = csr_mode;
            // set/clear with a zero operand must not write
            cf_w = !(csr_mode != 2'b01 && csr_src == '0);
          end
        end
        T_MSTATUS: begin
          cf_w        = 1'b1;
          cf_waddr    = MSTATUS_ADDR;
          cf_wsc      = 2'b01;
          cf_wdata    = cf_mstatus;
          cf_wdata[7] = cf_mstatus[3];
          cf_wdata[3] = 1'b0;
          w_next      = T_MEPC;
        end
        T_MEPC: begin
          cf_w     = 1'b1;
          cf_waddr = MEPC_ADDR;
          cf_wsc   = 2'b01;
          cf_wdata = r_epc;
          cf_raddr = MTVEC_ADDR;
          w_next   = T_MCAUSE;
        end
        T_MCAUSE: begin
          cf_w     = 1'b1;
          cf_waddr = MCAUSE_ADDR;
          cf_wsc   = 2'b01;
          cf_wdata = r_cause;
          cf_raddr = MTVEC_ADDR;
          w_next   = T_REDIR;
        end
        T_REDIR, R_REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = r_target;
          w_next         = IDLE;
        end
        R_MSTATUS: begin
          cf_w        = 1'b1;
          cf_waddr    = MSTATUS_ADDR;
          cf_wsc      = 2'b01;
          cf_wdata    = cf_mstatus;
          cf_wdata[3] = cf_mstatus[7];
          cf_wdata[7] = 1'b1;
          cf_raddr    = MEPC_ADDR;
          w_next      = R_REDIR;
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Scoreboard bench for csr_trap_sequencer with a behavioural CSR file.
// Expected writes and redirects are queued at stimulus time.
module tb_csr_trap_sequencer;

  logic        clk;
  logic        rst;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic        mret_req;
  logic        csr_req;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic [1:0]  csr_mode;
  logic        csr_gnt;
  logic [31:0] csr_rdata_out;
  logic        cf_w;
  logic [11:0] cf_raddr;
  logic [11:0] cf_waddr;
  logic [31:0] cf_wdata;
  logic [1:0]  cf_wsc;
  logic [31:0] cf_rdata;
  logic [31:0] cf_mstatus;
  logic        busy;
  logic        flush_all;
  logic        regwrite_cancel;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct {
    logic [11:0] a;
    logic [1:0]  m;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] pc;
    int          c;
  } rd_t;

  wr_t         q_wr[$];
  rd_t         q_rd[$];
  int          n_chk;
  int          n_err;
  int          cyc;
  logic [31:0] mem [4096];

  csr_trap_sequencer dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .mret_req(mret_req),
    .csr_req(csr_req), .csr_addr(csr_addr),
    .csr_src(csr_src), .csr_mode(csr_mode),
    .csr_gnt(csr_gnt), .csr_rdata_out(csr_rdata_out),
    .cf_w(cf_w), .cf_raddr(cf_raddr),
    .cf_waddr(cf_waddr), .cf_wdata(cf_wdata),
    .cf_wsc(cf_wsc), .cf_rdata(cf_rdata),
    .cf_mstatus(cf_mstatus), .busy(busy),
    .flush_all(flush_all),
    .regwrite_cancel(regwrite_cancel),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cf_rdata   = mem[cf_raddr];
  assign cf_mstatus = mem[12'h300];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    cyc = 0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cf_w) begin
      unique case (cf_wsc)
        2'b10:   mem[cf_waddr] <= mem[cf_waddr] | cf_wdata;
        2'b11:   mem[cf_waddr] <= mem[cf_waddr] & ~cf_wdata;
        default: mem[cf_waddr] <= cf_wdata;
      endcase
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && cf_w) begin
      if (q_wr.size() == 0) begin
        check("wr_extra", {20'h0, cf_waddr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q_wr.pop_front();
        check("wr_addr", {20'h0, cf_waddr}, {20'h0, e.a});
        check("wr_mode", {30'h0, cf_wsc}, {30'h0, e.m});
        check("wr_data", cf_wdata, e.d);
      end
    end
    if (rst === 1'b1 && redirect_valid) begin
      if (q_rd.size() == 0) begin
        check("rd_extra", redirect_pc, 32'hFFFF_FFFF);
      end else begin
        rd_t r;
        r = q_rd.pop_front();
        check("rd_pc", redirect_pc, r.pc);
        check("rd_lat", 32'(cyc), 32'(r.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_op(input logic [11:0] a,
                        input logic [31:0] s,
                        input logic [1:0]  m,
                        input logic        we,
                        input logic [31:0] old);
    csr_req  = 1'b1;
    csr_addr = a;
    csr_src  = s;
    csr_mode = m;
    if (we) q_wr.push_back('{a, m, s});
    @(negedge clk);
    check("csr_gnt", 32'(csr_gnt), 32'd1);
    check("csr_w", 32'(cf_w), 32'(we));
    check("csr_old", csr_rdata_out, old);
    tick();
    csr_req = 1'b0;
  endtask

  task automatic do_trap(input logic [31:0] epc,
                         input logic [31:0] cause,
                         input logic [31:0] mst,
                         input logic [31:0] pc,
                         input logic        hold);
    trap_req   = 1'b1;
    trap_epc   = epc;
    trap_cause = cause;
    q_wr.push_back('{12'h300, 2'b01, mst});
    q_wr.push_back('{12'h341, 2'b01, epc});
    q_wr.push_back('{12'h342, 2'b01, cause});
    q_rd.push_back('{pc, cyc + 4});
    if (hold) begin
      csr_req  = 1'b1;
      csr_addr = 12'h340;
      csr_src  = 32'h77;
      csr_mode = 2'b01;
      q_wr.push_back('{12'h340, 2'b01, 32'h77});
    end
    @(negedge clk);
    check("t_flush", 32'(flush_all), 32'd1);
    check("t_cancel", 32'(regwrite_cancel), 32'd1);
    check("t_gnt", 32'(csr_gnt), 32'd0);
    check("t_rdata0", csr_rdata_out, 32'd0);
    tick();
    trap_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("t_busy", 32'(busy), 32'd1);
      if (hold) check("t_stall_gnt", 32'(csr_gnt), 32'd0);
      tick();
    end
    @(negedge clk);
    check("t_idle", 32'(busy), 32'd0);
    if (hold) check("t_late_gnt", 32'(csr_gnt), 32'd1);
    tick();
    csr_req = 1'b0;
  endtask

  task automatic do_mret(input logic [31:0] mst,
                         input logic [31:0] pc);
    mret_req = 1'b1;
    q_wr.push_back('{12'h300, 2'b01, mst});
    q_rd.push_back('{pc, cyc + 2});
    @(negedge clk);
    check("m_flush", 32'(flush_all), 32'd1);
    check("m_cancel", 32'(regwrite_cancel), 32'd0);
    tick();
    mret_req = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check("m_busy", 32'(busy), 32'd1);
      tick();
    end
    @(negedge clk);
    check("m_idle", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] vec_pc;
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b0;
    trap_req   = 1'b1;
    mret_req   = 1'b1;
    csr_req    = 1'b1;
    trap_cause = 32'h5;
    trap_epc   = 32'h40;
    csr_addr   = 12'h305;
    csr_src    = 32'h1;
    csr_mode   = 2'b01;
    repeat (2) begin
      @(negedge clk);
      check("rst_flags",
            {26'h0, csr_gnt, cf_w, busy, flush_all,
             regwrite_cancel, redirect_valid}, 32'd0);
      check("rst_data",
            csr_rdata_out | cf_wdata | redirect_pc |
            {6'h0, cf_raddr, cf_waddr, cf_wsc}, 32'd0);
    end
    tick();
    rst      = 1'b1;
    trap_req = 1'b0;
    mret_req = 1'b0;
    csr_req  = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("idle_rdata0", csr_rdata_out, 32'd0);
    tick();

    csr_op(12'h305, 32'h100, 2'b01, 1'b1, 32'h0);
    csr_op(12'h305, 32'h0, 2'b10, 1'b0, 32'h100);
    csr_op(12'h300, 32'h8, 2'b01, 1'b1, 32'h0);
    csr_op(12'h340, 32'hF0, 2'b01, 1'b1, 32'h0);
    csr_op(12'h340, 32'h30, 2'b11, 1'b1, 32'hF0);
    csr_op(12'h340, 32'h0, 2'b11, 1'b0, 32'hC0);
    csr_op(12'h340, 32'h5, 2'b10, 1'b1, 32'hC0);

    do_trap(32'h2C, 32'h2, 32'h80, 32'h100, 1'b0);
    csr_op(12'h341, 32'h30, 2'b01, 1'b1, 32'h2C);
    do_mret(32'h88, 32'h30);

    csr_op(12'h300, 32'h8, 2'b01, 1'b1, 32'h88);
    do_trap(32'h44, 32'hB, 32'h80, 32'h100, 1'b1);
    csr_op(12'h340, 32'h0, 2'b10, 1'b0, 32'h77);

    csr_op(12'h305, 32'h101, 2'b01, 1'b1, 32'h100);
`ifdef TRAP_VECTORED_EN
    vec_pc = 32'h11C;
`else
    vec_pc = 32'h100;
`endif
    do_trap(32'h50, 32'h8000_0007, 32'h0, vec_pc, 1'b0);
    do_trap(32'h60, 32'h3, 32'h0, 32'h100, 1'b0);

    repeat (3) tick();
    check("wr_q_left", 32'(q_wr.size()), 32'd0);
    check("rd_q_left", 32'(q_rd.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
